// File: rtl/riscv_bus_arbiter_pkg.sv
// Shared types and constants for the RV32I bus arbiter and its steering muxes.
package riscv_bus_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    // Arbiter state encodings
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Select width for an n-way choice, never below one bit
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_mux.sv
// N-input, WIDTH-bit one-of-N selector; an out-of-range select yields zero.
module riscv_mux
    import riscv_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_MUX_IN = 2,
    parameter int unsigned WIDTH    = XLEN,
    parameter int unsigned SEL_W    = 1
) (
    input  logic [N_MUX_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [WIDTH-1:0]          o_data
);

    // Pick the input slice addressed by i_sel
    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < N_MUX_IN; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data = i_data[WIDTH*i +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/riscv_bus_arbiter.sv
// Shares one bus port among N_REQ requesters: one owner at a time, grant held
// until the bus acks, then a one-cycle done pulse with the registered read data.
// Build option: RISCV_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins); when undefined, arbitration is round-robin.
module riscv_bus_arbiter
    import riscv_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ-1:0]      i_req_we,
    input  logic [N_REQ*XLEN-1:0] i_req_addr,
    input  logic [N_REQ*XLEN-1:0] i_req_wdata,
    output logic [N_REQ-1:0]      o_req_gnt,
    output logic [N_REQ-1:0]      o_req_done,
    output logic [XLEN-1:0]       o_rsp_rdata,
    output logic                  o_bus_valid,
    output logic                  o_bus_we,
    output logic [XLEN-1:0]       o_bus_addr,
    output logic [XLEN-1:0]       o_bus_wdata,
    input  logic                  i_bus_ack,
    input  logic [XLEN-1:0]       i_bus_rdata
);

    localparam int unsigned SEL_W = sel_width(N_REQ);

    arb_state_e            state;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      r_ptr;
    logic [SEL_W-1:0]      winner;
    logic                  any_req;
    logic [N_REQ*XLEN-1:0] we_ext;
    logic [XLEN-1:0]       we_mux;
    logic                  unused_we_hi;

`ifdef RISCV_ARB_FIXED_PRIO_EN
    // Fixed priority: the scan always starts at requester 0
    assign r_ptr = '0;
`endif

    assign any_req = |i_req_valid;

    // First valid requester at or after r_ptr, wrapping to the lowest valid index
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                winner = SEL_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (SEL_W'(i) >= r_ptr)) begin
                winner = SEL_W'(i);
            end
        end
    end

    // Zero-extend each write-enable bit so it can ride a full-width mux
    always_comb begin
        we_ext = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            we_ext[XLEN*i +: XLEN] = XLEN'(i_req_we[i]);
        end
    end

    riscv_mux #(.N_MUX_IN(N_REQ), .WIDTH(XLEN), .SEL_W(SEL_W)) u_addr_mux (
        .i_data (i_req_addr),
        .i_sel  (r_sel),
        .o_data (o_bus_addr)
    );

    riscv_mux #(.N_MUX_IN(N_REQ), .WIDTH(XLEN), .SEL_W(SEL_W)) u_wdata_mux (
        .i_data (i_req_wdata),
        .i_sel  (r_sel),
        .o_data (o_bus_wdata)
    );

    riscv_mux #(.N_MUX_IN(N_REQ), .WIDTH(XLEN), .SEL_W(SEL_W)) u_we_mux (
        .i_data (we_ext),
        .i_sel  (r_sel),
        .o_data (we_mux)
    );

    assign o_bus_we     = we_mux[0];
    assign unused_we_hi = ^we_mux[XLEN-1:1];

    // Arbitration FSM with registered grant, done, read data and bus valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ARB_IDLE;
            r_sel       <= '0;
`ifndef RISCV_ARB_FIXED_PRIO_EN
            r_ptr       <= '0;
`endif
            o_req_gnt   <= '0;
            o_req_done  <= '0;
            o_rsp_rdata <= '0;
            o_bus_valid <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    o_req_done <= '0;
                    if (any_req) begin
                        r_sel       <= winner;
                        o_req_gnt   <= N_REQ'(1) << winner;
                        o_bus_valid <= 1'b1;
                        state       <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (i_bus_ack) begin
                        o_rsp_rdata <= i_bus_rdata;
                        o_bus_valid <= 1'b0;
                        o_req_gnt   <= '0;
                        o_req_done  <= N_REQ'(1) << r_sel;
                        state       <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    o_req_done <= '0;
`ifndef RISCV_ARB_FIXED_PRIO_EN
                    r_ptr      <= (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
`endif
                    state      <= ARB_IDLE;
                end
                default: begin
                    o_req_gnt   <= '0;
                    o_req_done  <= '0;
                    o_bus_valid <= 1'b0;
                    state       <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Scoreboard bench for riscv_bus_arbiter: the driver queues expected bus
// transactions and responses, a monitor checks them as the DUT presents them.
module tb_riscv_bus_arbiter;
    import riscv_bus_arbiter_pkg::*;

    localparam int unsigned N = 2;
`ifdef RISCV_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]    gnt;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [N-1:0]    done;
        logic [XLEN-1:0] rdata;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [XLEN-1:0] addr0, addr1, wdata0, wdata1;
    logic [N-1:0]    o_req_gnt, o_req_done;
    logic [XLEN-1:0] o_rsp_rdata, o_bus_addr, o_bus_wdata;
    logic            o_bus_valid, o_bus_we;
    logic            bus_ack, auto_ack, force_ack;
    logic [XLEN-1:0] bus_rdata;

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   ack_delay = 2;
    bit   auto_on = 1'b1;
    bus_t exp_bus[$];
    rsp_t exp_rsp[$];

    riscv_bus_arbiter #(.N_REQ(N)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_we    (req_we),
        .i_req_addr  ({addr1, addr0}),
        .i_req_wdata ({wdata1, wdata0}),
        .o_req_gnt   (o_req_gnt),
        .o_req_done  (o_req_done),
        .o_rsp_rdata (o_rsp_rdata),
        .o_bus_valid (o_bus_valid),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (bus_ack),
        .i_bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: fixed word at 0x100, otherwise address XOR 0xCAFE0000
    function automatic logic [XLEN-1:0] rdata_for(input logic [XLEN-1:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hCAFE_0000);
    endfunction

    assign bus_rdata = rdata_for(o_bus_addr);
    assign bus_ack   = auto_ack | force_ack;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_txn(input int idx, input logic we, input logic [XLEN-1:0] addr,
                           input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] rdata);
        bus_t b;
        rsp_t r;
        b.gnt   = N'(1) << idx;
        b.we    = we;
        b.addr  = addr;
        b.wdata = wdata;
        r.done  = N'(1) << idx;
        r.rdata = rdata;
        exp_bus.push_back(b);
        exp_rsp.push_back(r);
    endtask

    task automatic wait_done(input string name, output logic [N-1:0] mask);
        mask = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_req_done != '0) begin
                mask = o_req_done;
                break;
            end
        end
        if (mask == '0) begin
            tests++;
            fails++;
            $display("FAIL %s: no done pulse within 100 cycles, expected one", name);
        end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Bus responder: acks ack_delay cycles after o_bus_valid rises
    initial begin
        int cnt;
        cnt      = 0;
        auto_ack = 1'b0;
        forever begin
            tick();
            auto_ack = 1'b0;
            if (auto_on && o_bus_valid) begin
                if (cnt >= ack_delay) begin
                    auto_ack = 1'b1;
                    cnt      = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: checks each new bus transaction and each done pulse against the queues
    initial begin
        logic         prev_valid;
        logic [N-1:0] prev_done;
        bus_t         eb;
        rsp_t         er;
        prev_valid = 1'b0;
        prev_done  = '0;
        forever begin
            @(negedge clk);
            if (o_bus_valid && !prev_valid) begin
                if (exp_bus.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_txn: unexpected transaction gnt=%0h addr=%0h, none expected",
                             o_req_gnt, o_bus_addr);
                end else begin
                    eb = exp_bus.pop_front();
                    check("bus_txn", 128'({o_req_gnt, o_bus_we, o_bus_addr, o_bus_wdata}), 128'(eb));
                end
            end
            if (prev_done != '0) begin
                check("done_one_cycle", 128'(o_req_done), 128'(0));
            end else if (o_req_done != '0) begin
                done_cnt++;
                if (exp_rsp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp: unexpected done=%0h, none expected", o_req_done);
                end else begin
                    er = exp_rsp.pop_front();
                    check("rsp", 128'({o_req_done, o_rsp_rdata}), 128'(er));
                end
            end
            prev_valid = o_bus_valid;
            prev_done  = o_req_done;
        end
    end

    // Stimulus
    initial begin
        logic [N-1:0] mask;
        int           saved;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        addr0     = '0;
        addr1     = '0;
        wdata0    = '0;
        wdata1    = '0;
        force_ack = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_gnt",   128'(o_req_gnt),   128'(0));
        check("reset_done",  128'(o_req_done),  128'(0));
        check("reset_rdata", 128'(o_rsp_rdata), 128'(0));
        check("reset_valid", 128'(o_bus_valid), 128'(0));
        tick();
        rst = 1'b0;

        // Single read from req0, ack after three BUSY cycles
        tick();
        addr0     = 32'h0000_0100;
        req_valid = 2'b01;
        exp_txn(0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_valid_c1", 128'(o_bus_valid), 128'(0));
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("t1_valid_c2_4", 128'(o_bus_valid), 128'(1));
        end
        @(negedge clk);
        check("t1_done_c5",  128'(o_req_done),  128'(2'b01));
        check("t1_rdata_c5", 128'(o_rsp_rdata), 128'(32'hDEAD_BEEF));
        tick();
        req_valid = '0;
        repeat (2) tick();

        // Both requesters held from reset, ack one cycle after valid
        do_reset();
        ack_delay = 1;
        addr0     = 32'h0000_1000;
        addr1     = 32'h0000_2000;
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            if (FIXED || (j % 2 == 0)) exp_txn(0, 1'b0, 32'h0000_1000, 32'h0, 32'hCAFE_1000);
            else                       exp_txn(1, 1'b0, 32'h0000_2000, 32'h0, 32'hCAFE_2000);
        end
        for (int j = 0; j < 4; j++) wait_done("t3_both", mask);
        req_valid[0] = 1'b0;
        exp_txn(1, 1'b0, 32'h0000_2000, 32'h0, 32'hCAFE_2000);
        wait_done("t3_req1_after_drop", mask);
        req_valid = '0;
        repeat (2) tick();

        // Write from req1, then both valid: req0 must win next
        addr1     = 32'h0000_0200;
        wdata1    = 32'h1234_5678;
        req_we    = 2'b10;
        req_valid = 2'b10;
        exp_txn(1, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'hCAFE_0200);
        wait_done("t4_write", mask);
        req_valid = '0;
        req_we    = '0;
        wdata1    = '0;
        tick();
        addr0     = 32'h0000_0400;
        addr1     = 32'h0000_0500;
        req_valid = 2'b11;
        exp_txn(0, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_0400);
        exp_txn(1, 1'b0, 32'h0000_0500, 32'h0, 32'hCAFE_0500);
        for (int j = 0; j < 2; j++) begin
            wait_done("t4_ptr", mask);
            req_valid = req_valid & ~mask;
        end
        repeat (2) tick();

        // Ack while IDLE and while RESP must be ignored
        auto_on = 1'b0;
        tick();
        saved     = done_cnt;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        @(negedge clk);
        check("t5_idle_ack_done",  128'(o_req_done),  128'(0));
        check("t5_idle_ack_valid", 128'(o_bus_valid), 128'(0));
        check("t5_idle_ack_cnt",   128'(done_cnt),    128'(saved));
        tick();
        addr0     = 32'h0000_0300;
        req_valid = 2'b01;
        exp_txn(0, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_0300);
        tick();
        force_ack = 1'b1;
        tick();
        tick();
        req_valid = '0;
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_resp_ack_cnt",   128'(done_cnt),    128'(saved + 1));
        check("t5_resp_ack_valid", 128'(o_bus_valid), 128'(0));

        // Reset during BUSY abandons the transfer, then req0 wins
        tick();
        addr1     = 32'h0000_0600;
        req_valid = 2'b10;
        exp_bus.push_back('{gnt: 2'b10, we: 1'b0, addr: 32'h0000_0600, wdata: 32'h0});
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t6_rst_valid", 128'(o_bus_valid), 128'(0));
        check("t6_rst_gnt",   128'(o_req_gnt),   128'(0));
        check("t6_rst_done",  128'(o_req_done),  128'(0));
        tick();
        rst       = 1'b0;
        auto_on   = 1'b1;
        ack_delay = 0;
        addr0     = 32'h0000_0700;
        req_valid = 2'b11;
        exp_txn(0, 1'b0, 32'h0000_0700, 32'h0, 32'hCAFE_0700);
        exp_txn(1, 1'b0, 32'h0000_0600, 32'h0, 32'hCAFE_0600);
        for (int j = 0; j < 2; j++) begin
            wait_done("t6_after_rst", mask);
            req_valid = req_valid & ~mask;
        end

        repeat (5) tick();
        check("bus_queue_drained", 128'(exp_bus.size()), 128'(0));
        check("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
